// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared FSM states, constants and page-to-slot decode for periph_bus_ctrl
package periph_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;
  typedef struct packed {
    logic       hit;
    logic [3:0] slot;
  } dec_t;
  localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;
  localparam logic [15:0] RAM_PAGE = 16'h0000;
  function automatic dec_t decode_page(input logic [15:0] page, input logic [15:0] base, input int n);
    dec_t d;
    logic [15:0] off;
    off = page - base;
    d.hit = page == RAM_PAGE || off < 16'(n - 1);
    d.slot = page == RAM_PAGE ? 4'd0 : 4'(off + 16'd1);
    return d;
  endfunction
endpackage

// File: rtl/periph_bus_ctrl_if.sv
// periph_bus_ctrl_if: CPU request/response and slave strobe/response signals of the peripheral bus
interface periph_bus_ctrl_if #(parameter int N_SLOTS = 8) ();
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_rstrb;
  logic [31:0]           mem_rdata;
  logic                  mem_rbusy;
  logic                  mem_wbusy;
  logic [N_SLOTS-1:0]    s_cs;
  logic                  s_rd;
  logic                  s_wr;
  logic [3:0]            s_wmask;
  logic [31:0]           s_wdata;
  logic [32*N_SLOTS-1:0] s_rdata;
  logic [N_SLOTS-1:0]    s_ready;
  modport master (output mem_addr, mem_wdata, mem_wmask, mem_rstrb, input mem_rdata, mem_rbusy, mem_wbusy);
  modport slave (input s_cs, s_rd, s_wr, s_wmask, s_wdata, output s_rdata, s_ready);
  modport ctrl (
    input mem_addr, mem_wdata, mem_wmask, mem_rstrb, s_rdata, s_ready,
    output mem_rdata, mem_rbusy, mem_wbusy, s_cs, s_rd, s_wr, s_wmask, s_wdata
  );
endinterface

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts ACCESS cycles since acceptance and flags the last allowed one
module bus_timeout_ctr #(parameter int MAX = 15) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = run && cnt == 8'(MAX - 1);
  // restart on acceptance, advance once per ACCESS cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (start) cnt <= '0;
    else if (run) cnt <= cnt + 8'd1;
endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: page-decoded CPU-to-peripheral bus bridge; define BUS_TIMEOUT_EN to add the ready timeout
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int          N_SLOTS     = 8,
  parameter logic [15:0] BASE_PAGE   = 16'h0040,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  periph_bus_ctrl_if.ctrl   bus,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [31:0]       err_addr
);
  state_t             state;
  logic [31:0]        addr_q;
  logic               wr_q;
  logic               is_wr;
  logic               req;
  logic               rdy;
  logic               expired;
  logic               err_ev;
  logic [31:0]        sel_rdata;
  logic [N_SLOTS-1:0] dec_oh;
  dec_t               dec;
  assign is_wr = |bus.mem_wmask;
  assign req = is_wr || bus.mem_rstrb;
  assign dec = decode_page(bus.mem_addr[31:16], BASE_PAGE, N_SLOTS);
  assign dec_oh = dec.hit ? N_SLOTS'(1) << dec.slot : '0;
  assign rdy = |(bus.s_ready & bus.s_cs);
  assign err_ev = state == ERROR || (state == ACCESS && expired && !rdy);
`ifdef BUS_TIMEOUT_EN
  bus_timeout_ctr #(.MAX(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .start  (state == IDLE && req),
    .run    (state == ACCESS),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  // read data of the selected slot; s_cs is one-hot so OR-ing masked lanes is a mux
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_SLOTS; k++) sel_rdata = sel_rdata | (bus.s_cs[k] ? bus.s_rdata[32*k +: 32] : 32'h0);
  end
  // bus FSM with registered strobes, busy flags and read data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      wr_q <= 1'b0;
      bus.mem_rdata <= '0;
      bus.mem_rbusy <= 1'b0;
      bus.mem_wbusy <= 1'b0;
      bus.s_cs <= '0;
      bus.s_rd <= 1'b0;
      bus.s_wr <= 1'b0;
      bus.s_wmask <= '0;
      bus.s_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q <= bus.mem_addr;
          wr_q <= is_wr;
          bus.mem_rbusy <= !is_wr;
          bus.mem_wbusy <= is_wr;
          state <= dec.hit ? ACCESS : ERROR;
          bus.s_cs <= dec_oh;
          bus.s_rd <= dec.hit && !is_wr;
          bus.s_wr <= dec.hit && is_wr;
          bus.s_wmask <= dec.hit ? bus.mem_wmask : 4'h0;
          bus.s_wdata <= dec.hit ? bus.mem_wdata : 32'h0;
        end
        ACCESS: if (rdy || expired) begin
          if (!wr_q) bus.mem_rdata <= rdy ? sel_rdata : DEAD_DATA;
          bus.mem_rbusy <= 1'b0;
          bus.mem_wbusy <= 1'b0;
          bus.s_cs <= '0;
          bus.s_rd <= 1'b0;
          bus.s_wr <= 1'b0;
          bus.s_wmask <= '0;
          bus.s_wdata <= '0;
          state <= IDLE;
        end
        ERROR: begin
          if (!wr_q) bus.mem_rdata <= DEAD_DATA;
          bus.mem_rbusy <= 1'b0;
          bus.mem_wbusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // sticky first-error capture; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err_valid <= 1'b0;
      err_addr <= '0;
    end else if (err_ev && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_addr <= addr_q;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr <= '0;
    end
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl: directed checks of decode, wait states, errors, timeout and async reset
module tb_periph_bus_ctrl;
  import periph_bus_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        err_clr = 1'b0;
  logic        err_valid;
  logic [31:0] err_addr;
  int          total = 0;
  int          bad = 0;
  int          n;
  periph_bus_ctrl_if #(.N_SLOTS(8)) bus ();
  periph_bus_ctrl #(.N_SLOTS(8), .BASE_PAGE(16'h0040), .TIMEOUT_CYC(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err_clr  (err_clr),
    .err_valid(err_valid),
    .err_addr (err_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [31:0] a, input logic rs, input logic [3:0] wm, input logic [31:0] wd);
    bus.mem_addr = a;
    bus.mem_rstrb = rs;
    bus.mem_wmask = wm;
    bus.mem_wdata = wd;
    tick();
    bus.mem_rstrb = 1'b0;
    bus.mem_wmask = 4'h0;
  endtask
  initial begin
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;
    bus.s_rdata = '0;
    bus.s_ready = '0;
    tick();
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_busy", {30'h0, bus.mem_rbusy, bus.mem_wbusy}, 32'h0);
    chk("rst_cs", 32'(bus.s_cs), 32'h0);
    chk("rst_err", {31'h0, err_valid}, 32'h0);
    chk("rst_erraddr", err_addr, 32'h0);
    reset = 1'b0;
    bus.s_ready = 8'h01;
    bus.s_rdata[31:0] = 32'h1234_5678;
    req(32'h0000_0010, 1'b1, 4'h0, 32'h0);
    chk("rd_cs", 32'(bus.s_cs), 32'h01);
    chk("rd_srd", {30'h0, bus.s_rd, bus.s_wr}, 32'h2);
    chk("rd_busy1", {31'h0, bus.mem_rbusy}, 32'h1);
    tick();
    chk("rd_busy2", {31'h0, bus.mem_rbusy}, 32'h0);
    chk("rd_data", bus.mem_rdata, 32'h1234_5678);
    chk("rd_cs_off", 32'(bus.s_cs), 32'h0);
    bus.s_ready = 8'h00;
    req(32'h0041_0004, 1'b0, 4'b0011, 32'hA5A5_0F0F);
    chk("wr_cs", 32'(bus.s_cs), 32'h04);
    chk("wr_strb", {30'h0, bus.s_rd, bus.s_wr}, 32'h1);
    chk("wr_mask", 32'(bus.s_wmask), 32'h3);
    chk("wr_wdata", bus.s_wdata, 32'hA5A5_0F0F);
    n = 0;
    while (bus.mem_wbusy && n < 20) begin
      if (n == 3) bus.s_ready = 8'h04;
      tick();
      n++;
    end
    chk("wr_busy_len", n, 4);
    chk("wr_rdata_keep", bus.mem_rdata, 32'h1234_5678);
    chk("wr_cs_off", 32'(bus.s_cs), 32'h0);
    bus.s_ready = 8'h00;
    req(32'h0050_0000, 1'b1, 4'h0, 32'h0);
    chk("um_cs", 32'(bus.s_cs), 32'h0);
    chk("um_srd", {31'h0, bus.s_rd}, 32'h0);
    chk("um_busy1", {31'h0, bus.mem_rbusy}, 32'h1);
    tick();
    chk("um_busy2", {31'h0, bus.mem_rbusy}, 32'h0);
    chk("um_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    chk("um_err", {31'h0, err_valid}, 32'h1);
    chk("um_erraddr", err_addr, 32'h0050_0000);
    req(32'h0060_0000, 1'b0, 4'hF, 32'h1111_2222);
    tick();
    chk("um2_erraddr", err_addr, 32'h0050_0000);
    chk("um2_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    chk("um2_wbusy", {31'h0, bus.mem_wbusy}, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", {31'h0, err_valid}, 32'h0);
    chk("clr_erraddr", err_addr, 32'h0);
    req(32'h0070_0000, 1'b1, 4'h0, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_win", {31'h0, err_valid}, 32'h1);
    chk("errclr_addr", err_addr, 32'h0070_0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    req(32'h0042_0000, 1'b1, 4'h0, 32'h0);
    chk("to_cs", 32'(bus.s_cs), 32'h08);
    n = 0;
    while (bus.mem_rbusy && n < 40) begin
      tick();
      n++;
    end
`ifdef BUS_TIMEOUT_EN
    chk("to_len", n, 15);
    chk("to_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    chk("to_err", {31'h0, err_valid}, 32'h1);
    chk("to_erraddr", err_addr, 32'h0042_0000);
    req(32'h0042_0000, 1'b1, 4'h0, 32'h0);
`else
    chk("to_hold_busy", {31'h0, bus.mem_rbusy}, 32'h1);
    chk("to_hold_cs", 32'(bus.s_cs), 32'h08);
    chk("to_noerr", {31'h0, err_valid}, 32'h0);
    req(32'h0000_0000, 1'b1, 4'h0, 32'h0);
    chk("ignore_strb", 32'(bus.s_cs), 32'h08);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk("ar_cs", 32'(bus.s_cs), 32'h0);
    chk("ar_strb", {28'h0, bus.s_wmask}, 32'h0);
    chk("ar_rdwr", {30'h0, bus.s_rd, bus.s_wr}, 32'h0);
    chk("ar_busy", {30'h0, bus.mem_rbusy, bus.mem_wbusy}, 32'h0);
    chk("ar_rdata", bus.mem_rdata, 32'h0);
    chk("ar_err", {31'h0, err_valid}, 32'h0);
    chk("ar_erraddr", err_addr, 32'h0);
    reset = 1'b0;
    bus.s_ready = 8'h02;
    bus.s_rdata[63:32] = 32'hCAFE_F00D;
    req(32'h0040_0000, 1'b1, 4'h0, 32'h0);
    chk("pr_cs", 32'(bus.s_cs), 32'h02);
    tick();
    chk("pr_rdata", bus.mem_rdata, 32'hCAFE_F00D);
    chk("pr_busy", {31'h0, bus.mem_rbusy}, 32'h0);
    bus.s_ready = 8'h01;
    req(32'h0000_0020, 1'b1, 4'hF, 32'h5555_AAAA);
    chk("both_rdwr", {30'h0, bus.s_rd, bus.s_wr}, 32'h1);
    chk("both_busy", {30'h0, bus.mem_rbusy, bus.mem_wbusy}, 32'h1);
    chk("both_mask", 32'(bus.s_wmask), 32'hF);
    tick();
    chk("both_done", {31'h0, bus.mem_wbusy}, 32'h0);
    chk("both_rdata", bus.mem_rdata, 32'hCAFE_F00D);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/periph_bus_ctrl.md
PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 SHALL have parameter N_SLOTS, default 8: number of slave slots; slot 0 is RAM; range 2..16.
REQ-002 SHALL have parameter BASE_PAGE, default 16'h0040: page of slot 1; slot k (1..N_SLOTS-1) at BASE_PAGE+k-1.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 15: max wait cycles for slave ready; range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports mem_addr (input, 32), mem_wdata (input, 32), mem_wmask (input, 4) and mem_rstrb (input, 1): CPU request.
REQ-007 SHALL have ports mem_rdata (output, 32, registered), mem_rbusy (output, 1) and mem_wbusy (output, 1): CPU response.
REQ-008 SHALL have ports s_cs (output, N_SLOTS, one-hot), s_rd (output, 1), s_wr (output, 1) and s_wmask (output, 4): slave strobes.
REQ-009 SHALL have ports s_rdata (input, 32*N_SLOTS, slot k at bits 32k+31:32k) and s_ready (input, N_SLOTS): slave response.
REQ-010 SHALL have ports err_valid (output, 1) and err_addr (output, 32): sticky bus-error status; err_clr (input, 1) clears it.

Function
REQ-011 SHALL decode page mem_addr[31:16]: 16'h0000 -> slot 0; BASE_PAGE..BASE_PAGE+N_SLOTS-2 -> slots 1..N_SLOTS-1; any other page -> unmapped.
REQ-012 SHALL implement FSM IDLE -> ACCESS -> IDLE, plus ERROR (one cycle) -> IDLE.
REQ-013 SHALL, in IDLE, accept a request when mem_rstrb=1 or |mem_wmask=1; write SHALL win when both are set, and the read SHALL be dropped.
REQ-014 SHALL latch address, wdata, wmask, direction and slot at acceptance; the FSM SHALL go to ACCESS, or to ERROR if unmapped.
REQ-015 SHALL, in ACCESS, drive s_cs[slot]=1, s_rd or s_wr=1 and s_wmask=latched mask; all s_* SHALL be 0 in every other state.
REQ-016 SHALL, in ACCESS with s_ready[slot]=1: register s_rdata slot into mem_rdata on reads, leave mem_rdata unchanged on writes, and go to IDLE.
REQ-017 SHALL hold mem_rbusy (read) or mem_wbusy (write) high from the cycle after acceptance until the cycle mem_rdata is valid; minimum latency is 2 cycles from strobe to busy low.
REQ-018 SHALL ignore new strobes while not IDLE.
REQ-019 SHALL, on ERROR or timeout: load mem_rdata=32'hDEAD_BEEF for reads; set err_valid=1 and err_addr=latched address only if err_valid was 0 (first error kept); then return to IDLE.
REQ-020 SHALL clear err_valid/err_addr on err_clr; an error in the same cycle as err_clr SHALL win.
REQ-021 SHALL count ACCESS cycles; reaching TIMEOUT_CYC without ready SHALL count as a timeout; the counter SHALL restart at 0 on every acceptance.

Reset
REQ-022 SHALL, on reset asserted at any time including mid-access: state=IDLE, mem_rdata=0, busy=0, s_*=0, err_valid=0, err_addr=0, counter=0.
REQ-023 SHALL accept its first request on the first clk edge after reset deasserts.

Configuration
REQ-024 SHALL, with BUS_TIMEOUT_EN defined, include the timeout counter (REQ-021) and its error path.
REQ-025 SHALL, without BUS_TIMEOUT_EN, wait indefinitely in ACCESS, with unmapped-page errors (REQ-019) still active and no counter logic.

Structure
REQ-026 SHALL take the FSM state enum, DEAD_DATA=32'hDEAD_BEEF, RAM_PAGE=16'h0000 and the page-to-slot decode function from package periph_bus_pkg.
REQ-027 SHALL place the timeout counter in sub-module bus_timeout_ctr (clk, reset, start, run, expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-028 SHALL check a read: 0x0000_0010 with slot 0 ready in the first ACCESS cycle and s_rdata=0x1234_5678 -> s_cs=0x01, mem_rdata=0x1234_5678, rbusy low 2 cycles after strobe.
REQ-029 SHALL check a write: 0x0041_0004, wmask=4'b0011, slot 2 ready after 3 wait cycles -> s_cs=0x04, s_wmask=0011, wbusy high 4 cycles, mem_rdata unchanged.
REQ-030 SHALL check an unmapped read: 0x0050_0000 -> no s_cs, mem_rdata=0xDEAD_BEEF, err_valid=1, err_addr=0x0050_0000; a second error SHALL NOT change err_addr.
REQ-031 SHALL check a timeout: with BUS_TIMEOUT_EN, slot 3 never ready -> access ends after 15 ACCESS cycles with the 0xDEAD_BEEF error; without the macro -> busy stays high.
REQ-032 SHALL check reset asserted during ACCESS -> all outputs 0 immediately (asynchronous), then a new read at 0x0040_0000 completes normally.
REQ-033 SHALL check simultaneous rstrb and wmask=4'hF -> a write is performed, s_rd=0, wbusy asserted.
